// File: rtl/asrm_mem_unit.sv
// asrm_mem_unit: fetches one instruction per pass and, for stack and load/store
// codes, runs one extra data access before a single-cycle EXEC handshake to the CPU.
module asrm_mem_unit #(
    parameter int unsigned   WORDSIZE    = 16,
    parameter int unsigned   WAIT_STATES = 1,
    parameter logic [7:0]    INST_PUSH   = 8'h0C,
    parameter logic [7:0]    INST_POP    = 8'h0D,
    parameter logic [7:0]    INST_CALL   = 8'h0E,
    parameter logic [7:0]    INST_RET    = 8'h0F,
    parameter logic [3:0]    OPP_LOAD    = 4'hA,
    parameter logic [3:0]    OPP_STR     = 4'hB
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORDSIZE-1:0] workingRegister,
    input  logic [WORDSIZE-1:0] programCounter,
    input  logic [WORDSIZE-1:0] stackPointer,
    input  logic [WORDSIZE-1:0] otherRegister,
    output logic [7:0]          instruction,
    output logic [WORDSIZE-1:0] addr,
    output logic [WORDSIZE-1:0] data_out,
    input  logic [WORDSIZE-1:0] data_in,
    output logic                write_en,
    output logic                mem_req,
    input  logic                mem_ready,
    output logic [WORDSIZE-1:0] out,
    output logic [3:0]          out_reg,
    output logic                ram_not_ready
);

    typedef enum logic [1:0] {FETCH, DATA, EXEC} state_t;

    localparam logic [3:0] WS_MAX = 4'(WAIT_STATES);

    state_t     state, state_next;
    logic [3:0] counter;
    logic       done;

    // Write class: the data access stores a register to RAM.
    function automatic logic is_write(input logic [7:0] code);
        return (code == INST_PUSH) || (code == INST_CALL) || (code[7:4] == OPP_STR);
    endfunction

    // Read class: the data access returns a value to the CPU.
    function automatic logic is_read(input logic [7:0] code);
        return (code == INST_POP) || (code == INST_RET) || (code[7:4] == OPP_LOAD);
    endfunction

    // The full-code and opcode-nibble sets are disjoint, so memory class is just their union.
    function automatic logic is_mem(input logic [7:0] code);
        return is_write(code) || is_read(code);
    endfunction

    // An access finishes only once the minimum wait has elapsed and RAM agrees.
    assign done    = (counter == WS_MAX) && mem_ready;
    assign out_reg = 4'h0;

    // State register and wait counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            counter <= 4'h0;
        end else begin
            state <= state_next;
            if (state_next != state)
                counter <= 4'h0;
            else if (counter != WS_MAX)
                counter <= counter + 4'h1;
        end
    end

    // Capture the fetched code and the CPU result at access completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instruction <= 8'h00;
            out         <= '0;
        end else if (state == FETCH && done) begin
            instruction <= data_in[7:0];
            if (!is_mem(data_in[7:0]))
                out <= '0;
        end else if (state == DATA && done) begin
            out <= is_read(instruction) ? data_in : workingRegister;
        end
    end

    // Next-state: FETCH branches on the code arriving now, EXEC always returns to FETCH.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (done) state_next = is_mem(data_in[7:0]) ? DATA : EXEC;
            DATA:    if (done) state_next = EXEC;
            EXEC:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // RAM and CPU strobes decode only from registered state and instruction, so they hold
    // steady through stalls and cannot glitch.
    always_comb begin
        addr          = programCounter;
        data_out      = '0;
        write_en      = 1'b0;
        mem_req       = 1'b0;
        ram_not_ready = 1'b1;
        case (state)
            FETCH: mem_req = 1'b1;
            DATA: begin
                mem_req = 1'b1;
                if (instruction[7:4] == OPP_LOAD || instruction[7:4] == OPP_STR)
                    addr = otherRegister;
                else
                    addr = stackPointer;
                if (is_write(instruction)) begin
                    write_en = 1'b1;
                    data_out = (instruction == INST_CALL) ? programCounter : workingRegister;
                end
            end
            EXEC:    ram_not_ready = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_asrm_mem_unit.sv
// Bench for asrm_mem_unit: table of instructions run through a scripted RAM, with
// expected results queued at issue and compared at EXEC, plus stall and reset corners.
module tb_asrm_mem_unit;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] wr, pc, sp, oth, data_in, addr, data_out, out;
    logic [7:0]  instruction;
    logic [3:0]  out_reg;
    logic        write_en, mem_req, mem_ready, ram_not_ready;

    logic [7:0]  fetch_code;
    logic [15:0] rdata;

    // RAM model: the instruction lives at the PC, everything else returns rdata.
    assign data_in = (addr == pc) ? {8'hA5, fetch_code} : rdata;

    always #5 clk = ~clk;

    asrm_mem_unit #(.WORDSIZE(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .workingRegister(wr), .programCounter(pc), .stackPointer(sp), .otherRegister(oth),
        .instruction(instruction), .addr(addr), .data_out(data_out), .data_in(data_in),
        .write_en(write_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .out(out), .out_reg(out_reg), .ram_not_ready(ram_not_ready)
    );

    typedef struct {
        logic [7:0]  code;
        logic [15:0] pc, sp, wr, oth, rdata;
        bit          is_mem, exp_we;
        logic [15:0] exp_addr, exp_dout, exp_out;
        int          stall;
    } vec_t;

    typedef struct {
        logic [7:0]  instr;
        logic [15:0] out;
        int          cycles;
        int          data_cycles;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(input logic [7:0] code, input logic [15:0] vpc, vsp, vwr, voth,
                                vrd, input bit mem, we, input logic [15:0] ea, ed, eo,
                                input int stall);
        vec_t v;
        v.code = code; v.pc = vpc; v.sp = vsp; v.wr = vwr; v.oth = voth; v.rdata = vrd;
        v.is_mem = mem; v.exp_we = we; v.exp_addr = ea; v.exp_dout = ed; v.exp_out = eo;
        v.stall = stall;
        return v;
    endfunction

    // Called at the start of a FETCH cycle; returns at the start of the next FETCH.
    task automatic run_vec(input vec_t v);
        exp_t e, got;
        int   cyc, dcyc, stalled;
        bit   fin;
        pc = v.pc; sp = v.sp; wr = v.wr; oth = v.oth;
        fetch_code = v.code; rdata = v.rdata; mem_ready = 1'b1;
        e.instr = v.code;
        e.out = v.exp_out;
        e.data_cycles = v.is_mem ? ((v.stall + 1 > WS + 1) ? v.stall + 1 : WS + 1) : 0;
        e.cycles = v.is_mem ? (WS + 1) + e.data_cycles + 1 : WS + 2;
        sb.push_back(e);
        #1;
        cyc = 0; dcyc = 0; stalled = 0; fin = 0;
        while (!fin && cyc < 64) begin
            cyc++;
            if (!ram_not_ready) begin
                fin = 1;
                got = sb.pop_front();
                check("exec_instruction", instruction, got.instr);
                check("exec_out", out, got.out);
                check("exec_cycles", cyc, got.cycles);
                check("data_cycles", dcyc, got.data_cycles);
                check("exec_mem_req", mem_req, 1'b0);
                check("exec_write_en", write_en, 1'b0);
            end else begin
                if (!write_en) check("dout_zero", data_out, 16'h0);
                if (mem_req && addr != pc) begin
                    dcyc++;
                    check("data_addr", addr, v.exp_addr);
                    check("data_we", write_en, v.exp_we);
                    if (write_en) check("data_dout", data_out, v.exp_dout);
                    if (stalled < v.stall) begin
                        mem_ready = 1'b0;
                        stalled++;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end else begin
                    check("fetch_mem_req", mem_req, 1'b1);
                    check("fetch_we", write_en, 1'b0);
                end
                tick();
            end
        end
        mem_ready = 1'b1;
        if (!fin) begin
            check("exec_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        tick();
    endtask

    initial begin
        //          code   pc       sp       wr       oth      rdata    mem we addr     dout     out      stall
        tbl.push_back(mk(8'h05, 16'h0010, 16'h0000, 16'h9999, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(8'h0C, 16'h0020, 16'h0100, 16'hBEEF, 16'h0000, 16'h0000, 1, 1, 16'h0100, 16'hBEEF, 16'hBEEF, 0));
        tbl.push_back(mk(8'hA3, 16'h0030, 16'h0000, 16'h9999, 16'h0200, 16'h1234, 1, 0, 16'h0200, 16'h0000, 16'h1234, 0));
        tbl.push_back(mk(8'h0E, 16'h0042, 16'h00FE, 16'h5555, 16'h0000, 16'h0000, 1, 1, 16'h00FE, 16'h0042, 16'h5555, 0));
        tbl.push_back(mk(8'h0D, 16'h0050, 16'h0102, 16'h9999, 16'h0000, 16'hCAFE, 1, 0, 16'h0102, 16'h0000, 16'hCAFE, 0));
        tbl.push_back(mk(8'h0F, 16'h0060, 16'h0104, 16'h9999, 16'h0000, 16'h0ABC, 1, 0, 16'h0104, 16'h0000, 16'h0ABC, 0));
        tbl.push_back(mk(8'hB7, 16'h0070, 16'h0000, 16'h7777, 16'h0300, 16'h0000, 1, 1, 16'h0300, 16'h7777, 16'h7777, 0));
        tbl.push_back(mk(8'h1C, 16'h0074, 16'h0000, 16'h9999, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(8'h0D, 16'h0078, 16'h0106, 16'h9999, 16'h0000, 16'h4321, 1, 0, 16'h0106, 16'h0000, 16'h4321, 0));
        tbl.push_back(mk(8'hC3, 16'h007C, 16'h0000, 16'h9999, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(8'h0C, 16'h0080, 16'h0110, 16'h1111, 16'h0000, 16'h0000, 1, 1, 16'h0110, 16'h1111, 16'h1111, 3));

        pc = 16'h0010; sp = 16'h0; wr = 16'h0; oth = 16'h0;
        fetch_code = 8'h00; rdata = 16'h0; mem_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        check("rst_instruction", instruction, 8'h00);
        check("rst_out", out, 16'h0);
        check("rst_ram_not_ready", ram_not_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b1);
        check("rst_write_en", write_en, 1'b0);
        check("rst_addr", addr, 16'h0010);
        check("rst_out_reg", out_reg, 4'h0);
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset during the write phase of a push must abort it cleanly.
        begin
            int n;
            pc = 16'h0090; sp = 16'h0120; wr = 16'h2222; fetch_code = 8'h0C;
            #1;
            n = 0;
            while (!write_en && n < 20) begin
                tick();
                n++;
            end
            check("abort_reached_write", write_en, 1'b1);
            reset = 1'b0;
            tick();
            check("abort_write_en", write_en, 1'b0);
            check("abort_instruction", instruction, 8'h00);
            check("abort_out", out, 16'h0);
            check("abort_ram_not_ready", ram_not_ready, 1'b1);
            check("abort_mem_req", mem_req, 1'b1);
            check("abort_addr", addr, 16'h0090);
            reset = 1'b1;
        end

        run_vec(tbl[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
